// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM controller slice.
//  - cmd_t   : SDRAM command encodings {RAS_n, CAS_n, WE_n}
//  - A10_BIT : address bit that requests auto-precharge on READ/WRITE
//  - state_t : state encoding of the burst read engine (also exported as a debug output)
// Timing values are not here; they are module parameters.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_NOP   = 3'b111
  } cmd_t;

  localparam int A10_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACTIVATE = 3'd1,
    ST_RCD_WAIT = 3'd2,
    ST_READ_CMD = 3'd3,
    ST_CAS_WAIT = 3'd4,
    ST_CAPTURE  = 3'd5,
    ST_RP_WAIT  = 3'd6
  } state_t;

endpackage

// File: rtl/sdram_read_pack.sv
// sdram_read_pack: collects PACK consecutive DQ beats into one FIFO word.
// Ports:
//  clk, rst     clock, asynchronous active-high reset
//  capture      high in every cycle whose closing edge samples a valid beat
//  data_in      SDRAM DQ
//  fifo_data    packed word, updated together with fifo_write and held afterwards
//  fifo_write   one-cycle strobe, asserted the cycle after the PACK-th beat of a group
// Handshake: fifo_write is a plain strobe with no ready; the caller only starts a
// burst once the FIFO has room for all of its words, so a write is never refused.
module sdram_read_pack #(
  parameter int DQ_WIDTH  = 16,
  parameter int PACK      = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic [DQ_WIDTH-1:0]      data_in,
  output logic [DQ_WIDTH*PACK-1:0] fifo_data,
  output logic                     fifo_write
);

  localparam int W     = DQ_WIDTH * PACK;
  localparam int CNT_W = (PACK > 1) ? $clog2(PACK) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] slot;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_next;
  logic             group_done;

  // Beat k of a group lands in slot PACK-1-k (MSB first) or slot k (LSB first).
  always_comb begin
    slot       = MSB_FIRST ? (CNT_W'(PACK - 1) - cnt) : cnt;
    acc_next   = acc;
    acc_next[slot*DQ_WIDTH +: DQ_WIDTH] = data_in;
    group_done = (cnt == CNT_W'(PACK - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      fifo_data  <= '0;
      fifo_write <= 1'b0;
    end else begin
      fifo_write <= 1'b0;
      if (capture) begin
        if (group_done) begin
          fifo_data  <= acc_next;
          fifo_write <= 1'b1;
          cnt        <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sdram_burst_read.sv
// sdram_burst_read: SDRAM burst read engine.
// Issues ACT then READ with auto-precharge, captures BURST_LEN beats, packs them
// PACK per word into the read FIFO, then waits T_RP before going idle again.
// Ports:
//  clk, rst      clock, asynchronous active-high reset
//  command       SDRAM command (sdram_pkg::cmd_t encoding), NOP unless ACT/READ
//  address       row on ACT, {A10=1, column} on READ, 0 otherwise
//  bank          bank on ACT/READ, 0 otherwise
//  data_in       SDRAM DQ
//  enable        keep issuing bursts while high
//  idle          engine quiescent (state == IDLE)
//  auto_refresh  blocks new bursts; never interrupts one in flight
//  app_address   start address {bank, row, col}
//  fifo_data     packed read word
//  fifo_write    one-cycle write strobe per word
//  fifo_space    free FIFO entries, checked only before a burst starts
//  state         current FSM state (debug)
module sdram_burst_read
  import sdram_pkg::*;
#(
  parameter int DQ_WIDTH    = 16,
  parameter int PACK        = 2,
  parameter int BURST_LEN   = 8,
  parameter int ROW_WIDTH   = 12,
  parameter int COL_WIDTH   = 8,
  parameter int BANK_WIDTH  = 2,
  parameter int T_RCD       = 2,
  parameter int CAS_LAT     = 2,
  parameter int T_RP        = 2,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SPACE_WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  output logic [2:0]                               command,
  output logic [ROW_WIDTH-1:0]                     address,
  output logic [BANK_WIDTH-1:0]                    bank,
  input  logic [DQ_WIDTH-1:0]                      data_in,
  input  logic                                     enable,
  output logic                                     idle,
  input  logic                                     auto_refresh,
  input  logic [BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] app_address,
  output logic [DQ_WIDTH*PACK-1:0]                 fifo_data,
  output logic                                     fifo_write,
  input  logic [SPACE_WIDTH-1:0]                   fifo_space,
  output state_t                                   state
);

  localparam int ADDR_W    = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
  localparam int WORDS     = BURST_LEN / PACK;
  localparam int TMR_W     = 8;
  // Each wait state leaves when the timer (cleared on entry) reaches its last count.
  localparam int RCD_LAST  = (T_RCD > 1) ? T_RCD - 2 : 0;
  localparam int CAS_LAST  = (CAS_LAT > 1) ? CAS_LAT - 2 : 0;
  localparam int RP_LAST   = (T_RP > 0) ? T_RP - 1 : 0;
  localparam int BEAT_LAST = BURST_LEN - 1;

  state_t                  state_next;
  logic [TMR_W-1:0]        tmr;
  logic [ADDR_W-1:0]       rd_addr;
  logic [COL_WIDTH-1:0]    col;
  logic [ROW_WIDTH-1:0]    row;
  logic [BANK_WIDTH-1:0]   bnk;
  logic [ROW_WIDTH-1:0]    read_addr;
  logic                    start;
  logic                    capture;
  logic                    last_beat;

  assign col = rd_addr[COL_WIDTH-1:0];
  assign row = rd_addr[COL_WIDTH +: ROW_WIDTH];
  assign bnk = rd_addr[COL_WIDTH+ROW_WIDTH +: BANK_WIDTH];

  always_comb begin
    read_addr = '0;
    read_addr[COL_WIDTH-1:0] = col;
    read_addr[A10_BIT] = 1'b1;
  end

  assign start     = enable && !auto_refresh && (fifo_space >= SPACE_WIDTH'(WORDS));
  assign capture   = (state == ST_CAPTURE);
  assign last_beat = capture && (tmr == TMR_W'(BEAT_LAST));
  assign idle      = (state == ST_IDLE);

  always_comb begin
    state_next = state;
    command    = CMD_NOP;
    address    = '0;
    bank       = '0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_ACTIVATE;
      end
      ST_ACTIVATE: begin
        command    = CMD_ACT;
        address    = row;
        bank       = bnk;
        state_next = (T_RCD > 1) ? ST_RCD_WAIT : ST_READ_CMD;
      end
      ST_RCD_WAIT: begin
        if (tmr == TMR_W'(RCD_LAST)) state_next = ST_READ_CMD;
      end
      ST_READ_CMD: begin
        command    = CMD_READ;
        address    = read_addr;
        bank       = bnk;
        state_next = (CAS_LAT > 1) ? ST_CAS_WAIT : ST_CAPTURE;
      end
      ST_CAS_WAIT: begin
        if (tmr == TMR_W'(CAS_LAST)) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (last_beat) state_next = (T_RP > 0) ? ST_RP_WAIT : ST_IDLE;
      end
      ST_RP_WAIT: begin
        if (tmr == TMR_W'(RP_LAST)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      rd_addr <= '0;
    end else begin
      state <= state_next;
      tmr   <= (state_next != state) ? '0 : tmr + 1'b1;
      // app_address is tracked while the engine is idle and not streaming; once
      // enable is high, consecutive bursts continue from the advanced address.
      if (idle && !enable) begin
        rd_addr <= app_address;
      end else if (last_beat) begin
        rd_addr <= rd_addr + ADDR_W'(BURST_LEN);
      end
    end
  end

  sdram_read_pack #(
    .DQ_WIDTH  (DQ_WIDTH),
    .PACK      (PACK),
    .MSB_FIRST (MSB_FIRST)
  ) u_pack (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .data_in    (data_in),
    .fifo_data  (fifo_data),
    .fifo_write (fifo_write)
  );

endmodule

// File: tb/tb_sdram_burst_read.sv
// Bench for sdram_burst_read: a default instance (MSB first, PACK 2, BL 8, CL 2)
// and a second instance (LSB first, PACK 4, BL 4, CL 3). A behavioural SDRAM model
// answers every READ with random beats after CAS latency; the expected words and
// addresses are derived from those beats and the start address with plain arithmetic.
module tb_sdram_burst_read;
  import sdram_pkg::*;

  localparam int PACK = 2, BL = 8, CL = 2, RCD = 2;
  localparam int B_PACK = 4, B_BL = 4, B_CL = 3;

  typedef struct { int cyc; logic [11:0] addr; logic [1:0] bank; } cmd_rec_t;
  typedef struct { int cyc; logic [63:0] data; } wr_rec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A signals
  logic [2:0]  command;
  logic [11:0] address;
  logic [1:0]  bank;
  logic [15:0] data_in = '0;
  logic        enable = 1'b0, idle, auto_refresh = 1'b0;
  logic [21:0] app_address = '0;
  logic [31:0] fifo_data;
  logic        fifo_write;
  logic [7:0]  fifo_space = '0;
  state_t      state;

  // instance B signals
  logic [2:0]  b_command;
  logic [11:0] b_address;
  logic [1:0]  b_bank;
  logic [15:0] b_data_in = '0;
  logic        b_enable = 1'b0, b_idle, b_auto_refresh = 1'b0;
  logic [21:0] b_app_address = '0;
  logic [63:0] b_fifo_data;
  logic        b_fifo_write;
  logic [7:0]  b_fifo_space = '0;
  state_t      b_state;

  sdram_burst_read dut (
    .clk(clk), .rst(rst), .command(command), .address(address), .bank(bank),
    .data_in(data_in), .enable(enable), .idle(idle), .auto_refresh(auto_refresh),
    .app_address(app_address), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_space(fifo_space), .state(state)
  );

  sdram_burst_read #(.PACK(B_PACK), .BURST_LEN(B_BL), .CAS_LAT(B_CL), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .command(b_command), .address(b_address), .bank(b_bank),
    .data_in(b_data_in), .enable(b_enable), .idle(b_idle), .auto_refresh(b_auto_refresh),
    .app_address(b_app_address), .fifo_data(b_fifo_data), .fifo_write(b_fifo_write),
    .fifo_space(b_fifo_space), .state(b_state)
  );

  // observation queues and scoreboard
  cmd_rec_t    act_q[$], rd_q[$], b_act_q[$], b_rd_q[$];
  wr_rec_t     wr_q[$], b_wr_q[$];
  logic [15:0] beats_q[$], b_beats_q[$];
  logic [15:0] beat_at[int], b_beat_at[int];
  logic [31:0] exp_q[$];
  logic [15:0] beat_v;
  int          bad_cmd = 0;
  int          total = 0;
  int          bad = 0;

  // SDRAM + FIFO model, instance A: record commands/writes, serve READ data
  always @(negedge clk) begin
    if (command == CMD_ACT) act_q.push_back('{cyc, address, bank});
    else if (command == CMD_READ) begin
      rd_q.push_back('{cyc, address, bank});
      for (int i = 0; i < BL; i++) begin
        beat_v = 16'($urandom);
        beat_at[cyc + CL + i] = beat_v;
        beats_q.push_back(beat_v);
      end
    end else if (command != CMD_NOP) bad_cmd++;
    if (fifo_write) wr_q.push_back('{cyc, {32'h0, fifo_data}});
    if (beat_at.exists(cyc)) begin
      data_in = beat_at[cyc];
      beat_at.delete(cyc);
    end else data_in = 16'($urandom);
  end

  // SDRAM + FIFO model, instance B
  always @(negedge clk) begin
    if (b_command == CMD_ACT) b_act_q.push_back('{cyc, b_address, b_bank});
    else if (b_command == CMD_READ) begin
      b_rd_q.push_back('{cyc, b_address, b_bank});
      for (int i = 0; i < B_BL; i++) begin
        beat_v = 16'($urandom);
        b_beat_at[cyc + B_CL + i] = beat_v;
        b_beats_q.push_back(beat_v);
      end
    end else if (b_command != CMD_NOP) bad_cmd++;
    if (b_fifo_write) b_wr_q.push_back('{cyc, b_fifo_data});
    if (b_beat_at.exists(cyc)) begin
      b_data_in = b_beat_at[cyc];
      b_beat_at.delete(cyc);
    end else b_data_in = 16'($urandom);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_a();
    act_q.delete(); rd_q.delete(); wr_q.delete(); beats_q.delete(); exp_q.delete();
  endtask

  // Expected words for instance A: first beat of each group in the MSBs.
  function automatic void build_exp_a();
    logic [31:0] w;
    while (beats_q.size() >= PACK) begin
      w = '0;
      for (int k = 0; k < PACK; k++) w = (w << 16) | 32'(beats_q.pop_front());
      exp_q.push_back(w);
    end
  endfunction

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int t = 0;
    while (wr_q.size() < n && t < budget) begin tick(); t++; end
    ok = (wr_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (command !== CMD_NOP) begin bad++; $display("FAIL reset_cmd got=%0h want=%0h", command, CMD_NOP); end
    total++; if (fifo_write !== 1'b0) begin bad++; $display("FAIL reset_fifo_write got=%0b want=0", fifo_write); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0b want=1", idle); end
    total++; if (address !== 12'h0 || bank !== 2'h0) begin bad++; $display("FAIL reset_addr got=%0h/%0h want=0/0", address, bank); end
    total++; if (fifo_data !== 32'h0) begin bad++; $display("FAIL reset_fifo_data got=%0h want=0", fifo_data); end
    total++; if (b_idle !== 1'b1) begin bad++; $display("FAIL reset_b_idle got=%0b want=1", b_idle); end
    rst = 1'b0;
    tick();
  endtask

  // Two back-to-back bursts from start; checks addresses, timing and packed data.
  task automatic test_burst_stream(input logic [21:0] start);
    bit          ok;
    logic [21:0] ea;
    logic [31:0] ew;
    enable = 1'b0; auto_refresh = 1'b0; fifo_space = 8'd8; app_address = start;
    tick(); tick();
    clear_a();
    enable = 1'b1;
    wait_writes(2 * BL / PACK, 100, ok);
    enable = 1'b0;
    repeat (6) tick();
    total++; if (!ok) begin bad++; $display("FAIL stream_timeout got=%0d writes want=%0d", wr_q.size(), 2 * BL / PACK); end
    total++; if (act_q.size() != 2 || rd_q.size() != 2) begin bad++; $display("FAIL stream_cmd_count got=%0d/%0d want=2/2", act_q.size(), rd_q.size()); end
    total++; if (wr_q.size() != 2 * BL / PACK) begin bad++; $display("FAIL stream_write_count got=%0d want=%0d", wr_q.size(), 2 * BL / PACK); end
    for (int b = 0; b < act_q.size() && b < rd_q.size(); b++) begin
      ea = start + 22'(b * BL);
      total++; if (act_q[b].addr !== ea[19:8] || act_q[b].bank !== ea[21:20]) begin bad++; $display("FAIL act_addr%0d got=%0h/%0h want=%0h/%0h", b, act_q[b].addr, act_q[b].bank, ea[19:8], ea[21:20]); end
      total++; if (rd_q[b].addr !== (12'h400 | {4'h0, ea[7:0]}) || rd_q[b].bank !== ea[21:20]) begin bad++; $display("FAIL read_addr%0d got=%0h want=%0h", b, rd_q[b].addr, 12'h400 | {4'h0, ea[7:0]}); end
      total++; if (rd_q[b].cyc - act_q[b].cyc != RCD) begin bad++; $display("FAIL act_to_read%0d got=%0d want=%0d", b, rd_q[b].cyc - act_q[b].cyc, RCD); end
      if (wr_q.size() > b * (BL / PACK)) begin
        total++; if (wr_q[b * (BL / PACK)].cyc - act_q[b].cyc != RCD + CL + PACK) begin bad++; $display("FAIL act_to_write%0d got=%0d want=%0d", b, wr_q[b * (BL / PACK)].cyc - act_q[b].cyc, RCD + CL + PACK); end
      end
    end
    build_exp_a();
    for (int i = 0; i < wr_q.size(); i++) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL stream_word%0d got=%0h want=none", i, wr_q[i].data[31:0]); end
      else begin
        ew = exp_q.pop_front();
        if (wr_q[i].data[31:0] !== ew) begin bad++; $display("FAIL stream_word%0d got=%0h want=%0h", i, wr_q[i].data[31:0], ew); end
      end
    end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL stream_end_idle got=%0b want=1", idle); end
  endtask

  task automatic test_fifo_space();
    bit          ok;
    int          idle_low = 0;
    int          k;
    int          t = 0;
    logic [21:0] start;
    logic [31:0] ew;
    start = 22'($urandom) & ~22'h7;
    enable = 1'b0; auto_refresh = 1'b0; fifo_space = 8'd3; app_address = start;
    tick(); tick();
    clear_a();
    enable = 1'b1;
    repeat (12) begin tick(); if (!idle) idle_low++; end
    total++; if (act_q.size() != 0) begin bad++; $display("FAIL space_no_act got=%0d want=0", act_q.size()); end
    total++; if (idle_low != 0) begin bad++; $display("FAIL space_idle_low got=%0d want=0", idle_low); end
    k = cyc;
    fifo_space = 8'd4;
    while (act_q.size() == 0 && t < 5) begin tick(); t++; end
    fifo_space = 8'd0;  // must not stall the burst already started
    total++;
    if (act_q.size() == 0) begin bad++; $display("FAIL space_start got=no_act want=act_at_%0d", k + 1); end
    else if (act_q[0].cyc != k + 1) begin bad++; $display("FAIL space_start got=%0d want=%0d", act_q[0].cyc, k + 1); end
    wait_writes(BL / PACK, 40, ok);
    enable = 1'b0;
    repeat (6) tick();
    total++; if (wr_q.size() != BL / PACK) begin bad++; $display("FAIL space_write_count got=%0d want=%0d", wr_q.size(), BL / PACK); end
    if (act_q.size() > 0) begin
      total++; if (act_q[0].addr !== start[19:8] || act_q[0].bank !== start[21:20]) begin bad++; $display("FAIL space_act_addr got=%0h/%0h want=%0h/%0h", act_q[0].addr, act_q[0].bank, start[19:8], start[21:20]); end
    end
    build_exp_a();
    for (int i = 0; i < wr_q.size(); i++) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL space_word%0d got=%0h want=none", i, wr_q[i].data[31:0]); end
      else begin
        ew = exp_q.pop_front();
        if (wr_q[i].data[31:0] !== ew) begin bad++; $display("FAIL space_word%0d got=%0h want=%0h", i, wr_q[i].data[31:0], ew); end
      end
    end
  endtask

  task automatic test_refresh();
    bit          ok;
    logic [31:0] ew;
    enable = 1'b0; auto_refresh = 1'b1; fifo_space = 8'd8; app_address = 22'($urandom) & ~22'h7;
    tick(); tick();
    clear_a();
    enable = 1'b1;
    repeat (10) tick();
    total++; if (act_q.size() != 0 || idle !== 1'b1) begin bad++; $display("FAIL refresh_block got=%0d acts idle=%0b want=0 acts idle=1", act_q.size(), idle); end
    auto_refresh = 1'b0;
    wait_writes(1, 40, ok);
    auto_refresh = 1'b1;  // raised mid-capture: burst must still complete
    wait_writes(BL / PACK, 40, ok);
    repeat (10) tick();
    total++; if (wr_q.size() != BL / PACK) begin bad++; $display("FAIL refresh_write_count got=%0d want=%0d", wr_q.size(), BL / PACK); end
    total++; if (act_q.size() != 1 || idle !== 1'b1) begin bad++; $display("FAIL refresh_hold got=%0d acts idle=%0b want=1 act idle=1", act_q.size(), idle); end
    build_exp_a();
    for (int i = 0; i < wr_q.size(); i++) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL refresh_word%0d got=%0h want=none", i, wr_q[i].data[31:0]); end
      else begin
        ew = exp_q.pop_front();
        if (wr_q[i].data[31:0] !== ew) begin bad++; $display("FAIL refresh_word%0d got=%0h want=%0h", i, wr_q[i].data[31:0], ew); end
      end
    end
    enable = 1'b0; auto_refresh = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int acts;
    enable = 1'b0; auto_refresh = 1'b0; fifo_space = 8'd8; app_address = 22'($urandom) & ~22'h7;
    tick(); tick();
    clear_a();
    enable = 1'b1;
    wait_writes(1, 40, ok);
    total++; if (fifo_write !== 1'b1) begin bad++; $display("FAIL mid_pre_write got=%0b want=1", fifo_write); end
    rst = 1'b1;
    #1;
    total++; if (command !== CMD_NOP || fifo_write !== 1'b0) begin bad++; $display("FAIL mid_reset_out got=%0h/%0b want=%0h/0", command, fifo_write, CMD_NOP); end
    total++; if (idle !== 1'b1 || fifo_data !== 32'h0 || address !== 12'h0) begin bad++; $display("FAIL mid_reset_state got=idle%0b data%0h addr%0h want=idle1 data0 addr0", idle, fifo_data, address); end
    enable = 1'b0;
    tick(); tick();
    rst = 1'b0;
    wr_q.delete(); beats_q.delete();
    acts = act_q.size();
    repeat (12) tick();
    total++; if (wr_q.size() != 0 || act_q.size() != acts) begin bad++; $display("FAIL mid_reset_quiet got=%0d writes %0d acts want=0 writes %0d acts", wr_q.size(), act_q.size(), acts); end
  endtask

  task automatic test_lsb_first_pack4();
    int          t = 0;
    logic [63:0] ew;
    b_enable = 1'b0; b_auto_refresh = 1'b0; b_fifo_space = 8'd8; b_app_address = 22'($urandom) & ~22'h3;
    tick(); tick();
    b_act_q.delete(); b_rd_q.delete(); b_wr_q.delete(); b_beats_q.delete();
    b_enable = 1'b1;
    while (b_wr_q.size() == 0 && t < 40) begin tick(); t++; end
    b_enable = 1'b0;
    repeat (8) tick();
    total++; if (b_wr_q.size() != 1 || b_act_q.size() != 1 || b_rd_q.size() != 1) begin bad++; $display("FAIL lsb_counts got=%0d/%0d/%0d want=1/1/1", b_wr_q.size(), b_act_q.size(), b_rd_q.size()); end
    if (b_wr_q.size() > 0 && b_act_q.size() > 0 && b_rd_q.size() > 0) begin
      total++; if (b_wr_q[0].cyc - b_act_q[0].cyc != RCD + B_CL + B_PACK) begin bad++; $display("FAIL lsb_latency got=%0d want=%0d", b_wr_q[0].cyc - b_act_q[0].cyc, RCD + B_CL + B_PACK); end
      total++; if (b_rd_q[0].addr !== (12'h400 | {4'h0, b_app_address[7:0]})) begin bad++; $display("FAIL lsb_read_addr got=%0h want=%0h", b_rd_q[0].addr, 12'h400 | {4'h0, b_app_address[7:0]}); end
      if (b_beats_q.size() == B_BL) begin
        ew = '0;
        for (int k = 0; k < B_PACK; k++) ew = ew | (64'(b_beats_q[k]) << (16 * k));
        total++; if (b_wr_q[0].data !== ew) begin bad++; $display("FAIL lsb_word got=%0h want=%0h", b_wr_q[0].data, ew); end
        total++; if (b_wr_q[0].data[15:0] !== b_beats_q[0]) begin bad++; $display("FAIL lsb_first_beat got=%0h want=%0h", b_wr_q[0].data[15:0], b_beats_q[0]); end
      end
    end
  endtask

  task automatic test_command_legal();
    total++; if (bad_cmd != 0) begin bad++; $display("FAIL illegal_commands got=%0d want=0", bad_cmd); end
  endtask

  initial begin
    #1;
    test_reset();
    test_burst_stream(22'h01_2340);
    test_fifo_space();
    test_refresh();
    test_burst_stream(22'h3F_FFF8);
    test_reset_mid_burst();
    test_lsb_first_pack4();
    test_command_legal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
